// File: rtl/nebula_ni_packetizer.sv
// nebula_ni_packetizer: network-interface injection stage for a router local port.
// A descriptor (dst, vc, length) is split into packets of at most PKT_BEATS
// payload flits. Each packet is a HEAD flit followed by its payload beats,
// the final beat marked TAIL. All out_* fields come from one output register
// that only reloads when it is empty or being drained.
module nebula_ni_packetizer #(
    parameter int X_ID      = 0,
    parameter int Y_ID      = 0,
    parameter int PAYLOAD_W = 64,
    parameter int PKT_BEATS = 4,
    parameter int LEN_W     = 16,
    parameter int VCS       = 4,
    localparam int VC_W     = (VCS > 1) ? $clog2(VCS) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 msg_valid,
    output logic                 msg_ready,
    input  logic [7:0]           msg_dst_x,
    input  logic [7:0]           msg_dst_y,
    input  logic [VC_W-1:0]      msg_vc,
    input  logic [LEN_W-1:0]     msg_len,
    input  logic                 data_valid,
    output logic                 data_ready,
    input  logic [PAYLOAD_W-1:0] data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [1:0]           out_type,
    output logic [7:0]           out_dst_x,
    output logic [7:0]           out_dst_y,
    output logic [VC_W-1:0]      out_vc,
    output logic [PAYLOAD_W-1:0] out_payload,
    output logic                 busy,
    output logic                 err_zero_len,
    output logic [15:0]          pkt_sent
);

    localparam logic [1:0] TYPE_HEAD = 2'b01;
    localparam logic [1:0] TYPE_BODY = 2'b00;
    localparam logic [1:0] TYPE_TAIL = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2
    } state_e;

    state_e                 state_q, state_d;
    logic [7:0]             dst_x_q, dst_x_d;
    logic [7:0]             dst_y_q, dst_y_d;
    logic [VC_W-1:0]        vc_q, vc_d;
    logic [LEN_W-1:0]       remaining_q, remaining_d;
    logic [7:0]             seq_q, seq_d;
    logic [7:0]             beat_cnt_q, beat_cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [1:0]             out_type_q, out_type_d;
    logic [7:0]             out_dst_x_q, out_dst_x_d;
    logic [7:0]             out_dst_y_q, out_dst_y_d;
    logic [VC_W-1:0]        out_vc_q, out_vc_d;
    logic [PAYLOAD_W-1:0]   out_payload_q, out_payload_d;
    logic                   msg_ready_q, msg_ready_d;
    logic                   busy_q, busy_d;
    logic                   err_q, err_d;
    logic [15:0]            pkt_sent_q, pkt_sent_d;

    logic                   load_en_s;
    logic                   msg_fire_s;
    logic                   data_fire_s;
    logic [7:0]             nb_s;
    logic [PAYLOAD_W-1:0]   head_payload_s;

    // Output register may take a new flit when empty or draining this cycle.
    assign load_en_s   = !out_valid_q || out_ready;
    assign msg_fire_s  = msg_valid && msg_ready_q;
    assign data_ready  = (state_q == ST_BODY) && load_en_s;
    assign data_fire_s = data_valid && data_ready;

    // Packet size and HEAD flit payload for the packet about to start.
    always_comb begin
        if (remaining_q < LEN_W'(PKT_BEATS)) begin
            nb_s = 8'(remaining_q);
        end else begin
            nb_s = 8'(PKT_BEATS);
        end
        head_payload_s        = '0;
        head_payload_s[7:0]   = nb_s;
        head_payload_s[15:8]  = seq_q;
        head_payload_s[23:16] = 8'(X_ID);
        head_payload_s[31:24] = 8'(Y_ID);
    end

    // Next-state, output-register load and counter update.
    always_comb begin
        state_d       = state_q;
        dst_x_d       = dst_x_q;
        dst_y_d       = dst_y_q;
        vc_d          = vc_q;
        remaining_d   = remaining_q;
        seq_d         = seq_q;
        beat_cnt_d    = beat_cnt_q;
        out_type_d    = out_type_q;
        out_dst_x_d   = out_dst_x_q;
        out_dst_y_d   = out_dst_y_q;
        out_vc_d      = out_vc_q;
        out_payload_d = out_payload_q;
        err_d         = 1'b0;
        // A drained flit leaves the register empty unless a new one loads below.
        if (load_en_s) begin
            out_valid_d = 1'b0;
        end else begin
            out_valid_d = out_valid_q;
        end
        if (out_valid_q && out_ready && (out_type_q == TYPE_TAIL)) begin
            pkt_sent_d = pkt_sent_q + 16'd1;
        end else begin
            pkt_sent_d = pkt_sent_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (msg_fire_s) begin
                    if (msg_len == '0) begin
                        err_d = 1'b1;
                    end else begin
                        dst_x_d     = msg_dst_x;
                        dst_y_d     = msg_dst_y;
                        vc_d        = msg_vc;
                        remaining_d = msg_len;
                        seq_d       = 8'd0;
                        state_d     = ST_HEAD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_HEAD: begin
                if (load_en_s) begin
                    out_valid_d   = 1'b1;
                    out_type_d    = TYPE_HEAD;
                    out_dst_x_d   = dst_x_q;
                    out_dst_y_d   = dst_y_q;
                    out_vc_d      = vc_q;
                    out_payload_d = head_payload_s;
                    beat_cnt_d    = nb_s;
                    state_d       = ST_BODY;
                end else begin
                    state_d = ST_HEAD;
                end
            end
            ST_BODY: begin
                if (data_fire_s) begin
                    out_valid_d   = 1'b1;
                    out_dst_x_d   = dst_x_q;
                    out_dst_y_d   = dst_y_q;
                    out_vc_d      = vc_q;
                    out_payload_d = data;
                    beat_cnt_d    = beat_cnt_q - 8'd1;
                    if (remaining_q != '0) begin
                        remaining_d = remaining_q - LEN_W'(1);
                    end else begin
                        remaining_d = remaining_q;
                    end
                    if (beat_cnt_q == 8'd1) begin
                        out_type_d = TYPE_TAIL;
                        if (remaining_q > LEN_W'(1)) begin
                            seq_d   = seq_q + 8'd1;
                            state_d = ST_HEAD;
                        end else begin
                            state_d = ST_IDLE;
                        end
                    end else begin
                        out_type_d = TYPE_BODY;
                    end
                end else begin
                    state_d = ST_BODY;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        msg_ready_d = (state_d == ST_IDLE);
        busy_d      = (state_d != ST_IDLE) || out_valid_d;
    end

    // State, descriptor, counters and output register; reset discards everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_IDLE;
            dst_x_q       <= 8'd0;
            dst_y_q       <= 8'd0;
            vc_q          <= '0;
            remaining_q   <= '0;
            seq_q         <= 8'd0;
            beat_cnt_q    <= 8'd0;
            out_valid_q   <= 1'b0;
            out_type_q    <= 2'b00;
            out_dst_x_q   <= 8'd0;
            out_dst_y_q   <= 8'd0;
            out_vc_q      <= '0;
            out_payload_q <= '0;
            msg_ready_q   <= 1'b0;
            busy_q        <= 1'b0;
            err_q         <= 1'b0;
            pkt_sent_q    <= 16'd0;
        end else begin
            state_q       <= state_d;
            dst_x_q       <= dst_x_d;
            dst_y_q       <= dst_y_d;
            vc_q          <= vc_d;
            remaining_q   <= remaining_d;
            seq_q         <= seq_d;
            beat_cnt_q    <= beat_cnt_d;
            out_valid_q   <= out_valid_d;
            out_type_q    <= out_type_d;
            out_dst_x_q   <= out_dst_x_d;
            out_dst_y_q   <= out_dst_y_d;
            out_vc_q      <= out_vc_d;
            out_payload_q <= out_payload_d;
            msg_ready_q   <= msg_ready_d;
            busy_q        <= busy_d;
            err_q         <= err_d;
            pkt_sent_q    <= pkt_sent_d;
        end
    end

    assign msg_ready    = msg_ready_q;
    assign out_valid    = out_valid_q;
    assign out_type     = out_type_q;
    assign out_dst_x    = out_dst_x_q;
    assign out_dst_y    = out_dst_y_q;
    assign out_vc       = out_vc_q;
    assign out_payload  = out_payload_q;
    assign busy         = busy_q;
    assign err_zero_len = err_q;
    assign pkt_sent     = pkt_sent_q;

endmodule

// File: tb/tb_nebula_ni_packetizer.sv
// Bench for nebula_ni_packetizer: a reference model pushes expected flits
// into a scoreboard queue when a message is sent; a monitor pops and compares
// every flit handshaken on the output link.
module tb_nebula_ni_packetizer;

    localparam int X_ID      = 5;
    localparam int Y_ID      = 6;
    localparam int PAYLOAD_W = 64;
    localparam int PKT_BEATS = 4;
    localparam int LEN_W     = 16;
    localparam int VCS       = 4;
    localparam int VC_W      = 2;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 msg_valid;
    logic                 msg_ready;
    logic [7:0]           msg_dst_x;
    logic [7:0]           msg_dst_y;
    logic [VC_W-1:0]      msg_vc;
    logic [LEN_W-1:0]     msg_len;
    logic                 data_valid;
    logic                 data_ready;
    logic [PAYLOAD_W-1:0] data;
    logic                 out_valid;
    logic                 out_ready;
    logic [1:0]           out_type;
    logic [7:0]           out_dst_x;
    logic [7:0]           out_dst_y;
    logic [VC_W-1:0]      out_vc;
    logic [PAYLOAD_W-1:0] out_payload;
    logic                 busy;
    logic                 err_zero_len;
    logic [15:0]          pkt_sent;

    typedef struct packed {
        logic [1:0]           t;
        logic [7:0]           dx;
        logic [7:0]           dy;
        logic [VC_W-1:0]      vc;
        logic [PAYLOAD_W-1:0] pl;
    } flit_t;

    flit_t                exp_q[$];
    logic [PAYLOAD_W-1:0] dq[$];
    int                   n_checks = 0;
    int                   n_fail   = 0;
    int                   flit_cnt = 0;
    int                   msg_id   = 0;
    bit                   bubbles  = 1'b0;

    nebula_ni_packetizer #(
        .X_ID(X_ID), .Y_ID(Y_ID), .PAYLOAD_W(PAYLOAD_W),
        .PKT_BEATS(PKT_BEATS), .LEN_W(LEN_W), .VCS(VCS)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .msg_valid(msg_valid), .msg_ready(msg_ready),
        .msg_dst_x(msg_dst_x), .msg_dst_y(msg_dst_y),
        .msg_vc(msg_vc), .msg_len(msg_len),
        .data_valid(data_valid), .data_ready(data_ready), .data(data),
        .out_valid(out_valid), .out_ready(out_ready), .out_type(out_type),
        .out_dst_x(out_dst_x), .out_dst_y(out_dst_y), .out_vc(out_vc),
        .out_payload(out_payload), .busy(busy),
        .err_zero_len(err_zero_len), .pkt_sent(pkt_sent)
    );

    always #5 clk = ~clk;

    // Payload source: offers the head of dq, pops it when consumed.
    initial begin
        data_valid = 1'b0;
        data       = '0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                data_valid = 1'b0;
            end else begin
                data_valid = (dq.size() > 0) && (!bubbles || ($urandom_range(0, 1) == 1));
                data       = (dq.size() > 0) ? dq[0] : '0;
            end
            @(negedge clk);
            if (rst_n && data_valid && data_ready && dq.size() > 0) begin
                void'(dq.pop_front());
            end
        end
    end

    // Output monitor: every handshaken flit is checked against the scoreboard.
    initial begin
        flit_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready) begin
                flit_cnt++;
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL sb_unexpected: got type=%b pl=%h, expected no flit", out_type, out_payload);
                end else begin
                    e = exp_q.pop_front();
                    if ({out_type, out_dst_x, out_dst_y, out_vc, out_payload} !== e) begin
                        n_fail++;
                        $display("FAIL sb_flit: got type=%b dx=%h dy=%h vc=%h pl=%h, expected type=%b dx=%h dy=%h vc=%h pl=%h",
                                 out_type, out_dst_x, out_dst_y, out_vc, out_payload,
                                 e.t, e.dx, e.dy, e.vc, e.pl);
                    end
                end
            end
        end
    end

    // Model the packetization of one message, then hand the descriptor over.
    task automatic send_msg(input logic [7:0] dx, input logic [7:0] dy,
                            input logic [VC_W-1:0] vc, input int len);
        int rem;
        int nb;
        int beat;
        int waited;
        logic [7:0] seq;
        flit_t f;
        logic [PAYLOAD_W-1:0] pl;
        rem  = len;
        seq  = 8'd0;
        beat = 0;
        while (rem > 0) begin
            nb = (rem < PKT_BEATS) ? rem : PKT_BEATS;
            pl = '0;
            pl[7:0]   = 8'(nb);
            pl[15:8]  = seq;
            pl[23:16] = 8'(X_ID);
            pl[31:24] = 8'(Y_ID);
            f.t = 2'b01; f.dx = dx; f.dy = dy; f.vc = vc; f.pl = pl;
            exp_q.push_back(f);
            for (int j = 0; j < nb; j++) begin
                pl = {16'hDA7A, 16'(msg_id), 32'(beat)};
                beat++;
                dq.push_back(pl);
                f.t  = (j == nb - 1) ? 2'b10 : 2'b00;
                f.pl = pl;
                exp_q.push_back(f);
            end
            rem -= nb;
            seq++;
        end
        msg_id++;
        @(posedge clk);
        #1;
        msg_valid = 1'b1;
        msg_dst_x = dx;
        msg_dst_y = dy;
        msg_vc    = vc;
        msg_len   = 16'(len);
        waited    = 0;
        @(negedge clk);
        while (!msg_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        if (!msg_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL msg_accept_timeout: got msg_ready=%b after %0d cycles, expected 1", msg_ready, waited);
        end
        @(posedge clk);
        #1;
        msg_valid = 1'b0;
        msg_dst_x = 8'hEE;
        msg_dst_y = 8'hDD;
        msg_vc    = 2'd3;
        msg_len   = 16'd7;
    endtask

    // Let the link drain, optionally with random backpressure.
    task automatic wait_idle(input int budget, input bit rnd_ready);
        int c;
        c = 0;
        while ((exp_q.size() != 0 || busy) && c < budget) begin
            @(posedge clk);
            #1;
            if (rnd_ready) out_ready = ($urandom_range(0, 2) != 0);
            c++;
        end
        out_ready = 1'b1;
        n_checks++;
        if (exp_q.size() != 0 || busy) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d flits pending busy=%b, expected 0 pending busy=0", exp_q.size(), busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; msg_valid = 1'b0; out_ready = 1'b0;
        msg_dst_x = 8'd0; msg_dst_y = 8'd0; msg_vc = 2'd0; msg_len = 16'd0;
        #3;
        n_checks++;
        if ({out_valid, msg_ready, data_ready, busy, err_zero_len, pkt_sent, out_type, out_payload} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got valid=%b mrdy=%b drdy=%b busy=%b err=%b sent=%h, expected all 0",
                     out_valid, msg_ready, data_ready, busy, err_zero_len, pkt_sent);
        end
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b1;
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if (msg_ready !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: got msg_ready=%b busy=%b, expected 1 0", msg_ready, busy);
        end
    endtask

    task automatic test_single_packet();
        logic [1:0] et[4];
        int w;
        et[0] = 2'b01; et[1] = 2'b00; et[2] = 2'b00; et[3] = 2'b10;
        send_msg(8'd2, 8'd1, 2'd1, 3);
        w = 0;
        @(negedge clk);
        while (!out_valid && w < 10) begin
            @(negedge clk);
            w++;
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (out_valid !== 1'b1 || out_type !== et[i]) begin
                n_fail++;
                $display("FAIL single_seq[%0d]: got valid=%b type=%b, expected valid=1 type=%b", i, out_valid, out_type, et[i]);
            end
            @(negedge clk);
        end
        n_checks++;
        if (out_valid !== 1'b0 || pkt_sent !== 16'd1 || flit_cnt !== 4) begin
            n_fail++;
            $display("FAIL single_end: got valid=%b pkt_sent=%0d flits=%0d, expected 0 1 4", out_valid, pkt_sent, flit_cnt);
        end
    endtask

    task automatic test_multi_packet();
        int f0;
        f0 = flit_cnt;
        send_msg(8'd7, 8'd3, 2'd2, 10);
        wait_idle(200, 1'b0);
        n_checks++;
        if (flit_cnt - f0 !== 13 || pkt_sent !== 16'd4) begin
            n_fail++;
            $display("FAIL multi_counts: got flits=%0d pkt_sent=%0d, expected 13 4", flit_cnt - f0, pkt_sent);
        end
    endtask

    task automatic test_backpressure();
        logic [PAYLOAD_W+21-1:0] snap;
        int w;
        send_msg(8'd1, 8'd9, 2'd3, 8);
        w = 0;
        @(negedge clk);
        while (!(out_valid && out_type == 2'b00) && w < 20) begin
            @(negedge clk);
            w++;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        snap = {out_valid, out_type, out_dst_x, out_dst_y, out_vc, out_payload};
        n_checks++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_valid: got out_valid=%b, expected 1", out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_checks++;
            if ({out_valid, out_type, out_dst_x, out_dst_y, out_vc, out_payload} !== snap || data_ready !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got pl=%h drdy=%b, expected pl=%h drdy=0", i, out_payload, data_ready, snap[PAYLOAD_W-1:0]);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        wait_idle(200, 1'b0);
        n_checks++;
        if (pkt_sent !== 16'd6) begin
            n_fail++;
            $display("FAIL stall_sent: got pkt_sent=%0d, expected 6", pkt_sent);
        end
    endtask

    task automatic test_zero_len();
        int f0;
        f0 = flit_cnt;
        send_msg(8'd4, 8'd4, 2'd0, 0);
        @(negedge clk);
        n_checks++;
        if (err_zero_len !== 1'b1 || msg_ready !== 1'b1 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_pulse: got err=%b mrdy=%b valid=%b, expected 1 1 0", err_zero_len, msg_ready, out_valid);
        end
        @(negedge clk);
        n_checks++;
        if (err_zero_len !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_pulse_width: got err=%b, expected 0", err_zero_len);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (flit_cnt !== f0 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_noflit: got flits=%0d busy=%b valid=%b, expected %0d 0 0", flit_cnt, busy, out_valid, f0);
        end
    endtask

    task automatic test_back_to_back();
        int f0;
        f0 = flit_cnt;
        bubbles = 1'b1;
        send_msg(8'd10, 8'd11, 2'd1, 5);
        send_msg(8'd12, 8'd13, 2'd2, 3);
        wait_idle(600, 1'b1);
        bubbles = 1'b0;
        n_checks++;
        if (flit_cnt - f0 !== 11 || pkt_sent !== 16'd9) begin
            n_fail++;
            $display("FAIL b2b_counts: got flits=%0d pkt_sent=%0d, expected 11 9", flit_cnt - f0, pkt_sent);
        end
    endtask

    task automatic test_reset_mid();
        int f0;
        send_msg(8'd3, 8'd3, 2'd1, 8);
        repeat (3) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, msg_ready, data_ready, pkt_sent, out_payload} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got valid=%b busy=%b mrdy=%b drdy=%b sent=%h pl=%h, expected all 0",
                     out_valid, busy, msg_ready, data_ready, pkt_sent, out_payload);
        end
        exp_q.delete();
        dq.delete();
        repeat (2) @(posedge clk);
        #2;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        f0 = flit_cnt;
        send_msg(8'd8, 8'd2, 2'd0, 5);
        wait_idle(200, 1'b0);
        n_checks++;
        if (pkt_sent !== 16'd2 || flit_cnt - f0 !== 7) begin
            n_fail++;
            $display("FAIL post_reset: got pkt_sent=%0d flits=%0d, expected 2 7", pkt_sent, flit_cnt - f0);
        end
    endtask

    task automatic test_pkt_sent_wrap();
        @(posedge clk);
        #1;
        force dut.pkt_sent_q = 16'hFFFE;
        @(negedge clk);
        release dut.pkt_sent_q;
        send_msg(8'd1, 8'd1, 2'd0, 3);
        wait_idle(100, 1'b0);
        n_checks++;
        if (pkt_sent !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL wrap_ffff: got pkt_sent=%h, expected ffff", pkt_sent);
        end
        send_msg(8'd1, 8'd1, 2'd0, 1);
        wait_idle(100, 1'b0);
        n_checks++;
        if (pkt_sent !== 16'h0000) begin
            n_fail++;
            $display("FAIL wrap_zero: got pkt_sent=%h, expected 0000", pkt_sent);
        end
        send_msg(8'd1, 8'd1, 2'd0, 4);
        wait_idle(100, 1'b0);
        n_checks++;
        if (pkt_sent !== 16'h0001) begin
            n_fail++;
            $display("FAIL wrap_one: got pkt_sent=%h, expected 0001", pkt_sent);
        end
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_multi_packet();
        test_backpressure();
        test_zero_len();
        test_back_to_back();
        test_reset_mid();
        test_pkt_sent_wrap();
        repeat (3) @(negedge clk);
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_leftover: got %0d unmatched flits, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: got simulation still running, expected finish");
        $fatal(1, "timeout");
    end

endmodule
